btn_event_arbiter: RTL
======================

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter NUM_BTN, default 4, number of debounced button pulse inputs (2..8).
REQ-002 Parameter FIFO_DEPTH, default 4, event queue entries (power of two, 2..16).
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_i  input  NUM_BTN  per-button one-cycle press pulses from debouncer outputs.
REQ-006 Port flush_i  input  1  synchronous clear of all pending events and queue.
REQ-007 Port evt_valid  output  1  queue head holds an event.
REQ-008 Port evt_id  output  clog2(NUM_BTN)  button index of queue head.
REQ-009 Port evt_ready  input  1  consumer accepts head when high with evt_valid.
REQ-010 Port busy  output  1  any pending bit set or queue non-empty.
REQ-011 Port drop_o  output  1  one-cycle pulse when any press is discarded.

Function
REQ-012 Each button SHALL own a pending bit, set on the edge after req_i[i] is high.
REQ-013 A pulse on req_i[i] while pending[i] is set and not granted that cycle SHALL be discarded and assert drop_o next cycle.
REQ-014 A pulse on req_i[i] in the same cycle pending[i] is granted SHALL leave pending[i] set (new event, no drop).
REQ-015 Each cycle with any pending bit set and queue count < FIFO_DEPTH, exactly one button SHALL be granted: its index written to the queue and its pending bit cleared.
REQ-016 Grant selection SHALL be round-robin: search starts at last-granted index + 1, modulo NUM_BTN; pointer updates only on grant.
REQ-017 Full check SHALL use the registered count; a pop in the same cycle does not enable a push when full.
REQ-018 Queue SHALL be FIFO; evt_valid = count != 0; evt_id = head entry, registered.
REQ-019 Pop SHALL occur on evt_valid & evt_ready; push and pop in one cycle keep count unchanged.
REQ-020 evt_id SHALL hold stable while evt_valid & ~evt_ready.
REQ-021 Minimum latency: req_i at cycle t -> evt_valid high at cycle t+2 with empty queue.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-023 flush_i SHALL take priority: next cycle pending = 0, count = 0, pointers = 0, RR pointer unchanged, req_i of that cycle ignored, no drop_o.
REQ-024 busy SHALL be combinational from registered pending and count.

Reset
REQ-025 reset_n low SHALL immediately clear pending, queue pointers, count, RR pointer (to NUM_BTN-1 so index 0 wins first), drop_o, evt_valid, evt_id to 0.
REQ-026 Reset mid-operation SHALL discard all queued events; first grant after release behaves as from power-up.

Configuration
REQ-027 Macro BTN_ARB_DROP_CNT_EN defined: add output drop_cnt (8 bits), incremented per drop_o pulse, saturates at 255, cleared by reset and flush_i.
REQ-028 Macro undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-029 Single press: req_i=0001 at t, evt_ready=1 -> evt_valid at t+2, evt_id=0, one cycle only, busy low at t+3.
REQ-030 Simultaneous: req_i=1111 at one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on consecutive cycles, no drop_o.
REQ-031 Backpressure: evt_ready=0, pulses on buttons 0,1,2,3 then 0 again after queue full -> count=4, pending[0] held, second button-0 pulse before grant asserts drop_o; with macro drop_cnt=1.
REQ-032 Grant/re-press: req_i[2] pulsed in the cycle pending[2] is granted -> two events id=2 delivered, drop_o never asserted.
REQ-033 Flush: queue holding 3 events, pending 0010, flush_i one cycle -> evt_valid=0, busy=0 next cycle; subsequent press of button 3 delivers id=3 first.
REQ-034 Async reset: assert reset_n low mid-burst off-clock-edge -> outputs 0 before next edge; after release, press 1 -> evt_id=1 at t+2.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// Button event arbiter: per-button pending bits, round-robin grant into a small event FIFO.
// Optional saturating drop counter output enabled by defining BTN_ARB_DROP_CNT_EN.
module btn_event_arbiter #(
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_BTN-1:0]         req_i,
  input  logic                       flush_i,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic                       busy,
  output logic                       drop_o
`ifdef BTN_ARB_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int unsigned IdW  = $clog2(NUM_BTN);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [IdW-1:0]     rr_q, rr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               drop_q, drop_d;
  logic [IdW-1:0]     evt_id_q, evt_id_d;
  logic [IdW-1:0]     mem_q [FIFO_DEPTH];

  logic               full;
  logic               pop;
  logic               grant_vld;
  logic [IdW-1:0]     grant_idx;
  logic [IdW-1:0]     scan_idx;
  logic [NUM_BTN-1:0] grant_oh;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign evt_id    = evt_id_q;
  assign drop_o    = drop_q;
  assign busy      = (|pending_q) | (count_q != '0);
  assign grant_oh  = grant_vld ? (NUM_BTN'(1) << grant_idx) : '0;

  // Round-robin search starting one past the last granted button.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NUM_BTN; k++) begin
      scan_idx = IdW'((32'(rr_q) + k) % NUM_BTN);
      if (!grant_vld && !full && pending_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Next-state for pending bits, queue pointers, head register and drop pulse.
  always_comb begin
    pending_d = (pending_q & ~grant_oh) | req_i;
    drop_d    = |(req_i & pending_q & ~grant_oh);
    rr_d      = grant_vld ? grant_idx : rr_q;
    wr_ptr_d  = grant_vld ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + CntW'(grant_vld) - CntW'(pop);
    // New entry becomes head when it lands exactly at the next read slot.
    if (count_d == '0) begin
      evt_id_d = evt_id_q;
    end else if (grant_vld && (rd_ptr_d == wr_ptr_q)) begin
      evt_id_d = grant_idx;
    end else begin
      evt_id_d = mem_q[rd_ptr_d];
    end
    if (flush_i) begin
      pending_d = '0;
      drop_d    = 1'b0;
      rr_d      = rr_q;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      evt_id_d  = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rr_q      <= IdW'(NUM_BTN - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
      evt_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      evt_id_q  <= evt_id_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (grant_vld && !flush_i) begin
      mem_q[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef BTN_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  // Saturating count of discarded presses, tracking drop_o.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      drop_cnt_d = '0;
    end else if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule
